// File: rtl/hs_cdc_rx.sv
// Destination-side responder of a 4-phase req/ack CDC handshake with a valid/ready output port.
// Define SYNC_3FF_EN to use a 3-flop request synchroniser instead of the default 2-flop one.
module hs_cdc_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_async,
  input  logic [DATA_W-1:0] data_async,
  output logic              ack,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy
);

`ifdef SYNC_3FF_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  // Handshake on dout: a transfer happens on a rising clk edge where
  // dout_valid and dout_ready are both high; dout/dout_valid hold until then.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ACK_HI  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_N-1:0]   req_sync_q;
  logic                req_s;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;

  assign req_s = req_sync_q[SYNC_N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q   <= '0;
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      req_sync_q   <= {req_sync_q[SYNC_N-2:0], req_async};
      state_q      <= state_d;
      ack_q        <= ack_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // data_async is only sampled once req_s is high, when the source holds it stable.
  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          dout_d       = data_async;
          dout_valid_d = 1'b1;
          state_d      = PRESENT;
        end
      end
      PRESENT: begin
        if (dout_valid_q && dout_ready) begin
          dout_valid_d = 1'b0;
          ack_d        = 1'b1;
          state_d      = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d        = 1'b0;
        dout_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  assign ack        = ack_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hs_cdc_rx.sv
// Self-checking bench for hs_cdc_rx: latency, backpressure, early req drop, back-to-back and reset.
// Build with SYNC_3FF_EN defined to check the 3-flop synchroniser latencies.
module tb_hs_cdc_rx;
  localparam int DATA_W = 8;
`ifdef SYNC_3FF_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_async;
  logic [DATA_W-1:0] data_async;
  logic              ack;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int xfer_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  hs_cdc_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_async (req_async),
    .data_async(data_async),
    .ack       (ack),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1ns after a rising edge; outputs are sampled on falling edges.
  task automatic drive_step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: each accepted dout is matched against the queue
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (ack && !busy) begin
        failures++;
        $display("FAIL ack_in_idle: ack=%b busy=%b required ack=0 when idle", ack, busy);
      end
      if (dout_valid && dout_ready) begin
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: dout=%h with empty expected queue", dout);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (dout !== e) begin
            failures++;
            $display("FAIL sb_data: dout=%h required %h", dout, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req_async = 1'b0; data_async = '0; dout_ready = 1'b0;
    #12;
    checks++;
    if ({ack, dout_valid, dout, busy} !== {1'b0, 1'b0, {DATA_W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: ack=%b valid=%b dout=%h busy=%b required all 0", ack, dout_valid, dout, busy);
    end
    drive_step();
    rst_n = 1'b1;
    repeat (3) drive_step();
  endtask

  task automatic test_single(input logic [DATA_W-1:0] d);
    logic ev, ea;
    dout_ready = 1'b1; data_async = d; req_async = 1'b1;
    exp_q.push_back(d);
    @(posedge clk);  // edge N
    for (int k = 0; k <= SYNC_N + 3; k++) begin
      @(negedge clk);
      ev = (k == SYNC_N);
      ea = (k >= SYNC_N + 1);
      checks++;
      if (dout_valid !== ev || ack !== ea) begin
        failures++;
        $display("FAIL single_rise k=%0d: valid=%b ack=%b required valid=%b ack=%b", k, dout_valid, ack, ev, ea);
      end
      if (ev) begin
        checks++;
        if (dout !== d) begin
          failures++;
          $display("FAIL single_dout: dout=%h required %h", dout, d);
        end
      end
    end
    drive_step();
    req_async = 1'b0;
    @(posedge clk);  // edge M
    for (int k = 0; k <= SYNC_N + 1; k++) begin
      @(negedge clk);
      ea = (k < SYNC_N);
      checks++;
      if (ack !== ea || busy !== ea) begin
        failures++;
        $display("FAIL single_fall k=%0d: ack=%b busy=%b required %b", k, ack, busy, ea);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    dout_ready = 1'b0; data_async = 8'h3C; req_async = 1'b1;
    exp_q.push_back(8'h3C);
    n = 0;
    while (!dout_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!dout_valid) begin
      failures++;
      $display("FAIL bp_valid_timeout: valid=%b required 1", dout_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'h3C || ack !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: valid=%b dout=%h ack=%b required 1/3c/0", dout_valid, dout, ack);
      end
    end
    drive_step();
    dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0 || ack !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: valid=%b ack=%b required 0/1", dout_valid, ack);
    end
    drive_step();
    req_async = 1'b0;
    n = 0;
    while (ack && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_ack_drop: ack=%b busy=%b required 0/0", ack, busy);
    end
  endtask

  task automatic test_early_drop();
    int x0;
    logic [DATA_W-1:0] d;
    int hi;
    d = 8'($urandom_range(0, 255));
    x0 = xfer_cnt;
    dout_ready = 1'b0; data_async = d; req_async = 1'b1;
    exp_q.push_back(d);
    repeat (4) drive_step();
    req_async = 1'b0;
    data_async = ~d;
    repeat (6) drive_step();
    checks++;
    if (dout_valid !== 1'b1 || dout !== d || ack !== 1'b0) begin
      failures++;
      $display("FAIL early_present: valid=%b dout=%h ack=%b required 1/%h/0", dout_valid, dout, ack, d);
    end
    dout_ready = 1'b1;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) hi++;
    end
    checks++;
    if (hi !== 1) begin
      failures++;
      $display("FAIL early_ack_pulse: ack high %0d cycles required 1", hi);
    end
    checks++;
    if (xfer_cnt - x0 !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL early_xfer: transfers=%0d busy=%b required 1/0", xfer_cnt - x0, busy);
    end
    drive_step();
    dout_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int x0, n;
    x0 = xfer_cnt;
    for (int t = 0; t < 16; t++) begin
      drive_step();
      data_async = 8'($urandom_range(0, 255));
      exp_q.push_back(data_async);
      req_async = 1'b1;
      n = 0;
      while (!ack && n < 200) begin
        drive_step();
        dout_ready = 1'($urandom_range(0, 1));
        n++;
      end
      checks++;
      if (!ack) begin
        failures++;
        $display("FAIL b2b_ack_rise t=%0d: ack=%b required 1", t, ack);
      end
      req_async = 1'b0;
      n = 0;
      while (ack && n < 50) begin
        drive_step();
        dout_ready = 1'($urandom_range(0, 1));
        n++;
      end
      checks++;
      if (ack) begin
        failures++;
        $display("FAIL b2b_ack_fall t=%0d: ack=%b required 0", t, ack);
      end
    end
    repeat (4) drive_step();
    checks++;
    if (xfer_cnt - x0 !== 16 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_count: transfers=%0d pending=%0d required 16/0", xfer_cnt - x0, exp_q.size());
    end
    dout_ready = 1'b0;
  endtask

  task automatic test_reset_mid_ack();
    int n;
    dout_ready = 1'b1; data_async = 8'h5A; req_async = 1'b1;
    exp_q.push_back(8'h5A);
    n = 0;
    while (!ack && n < 20) begin drive_step(); n++; end
    checks++;
    if (ack !== 1'b1 || dout !== 8'h5A) begin
      failures++;
      $display("FAIL rst_mid_setup: ack=%b dout=%h required 1/5a", ack, dout);
    end
    drive_step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, dout_valid, dout, busy} !== {1'b0, 1'b0, {DATA_W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_async: ack=%b valid=%b dout=%h busy=%b required all 0", ack, dout_valid, dout, busy);
    end
    exp_q.delete();
    req_async = 1'b0;
    drive_step();
    rst_n = 1'b1;
    repeat (4) drive_step();
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_after: ack=%b busy=%b valid=%b required 0", ack, busy, dout_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_backpressure();
    test_early_drop();
    test_back_to_back();
    test_single(8'h96);
    test_reset_mid_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
